// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the countdown timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Register offsets, taken from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_W        = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer raising a held interrupt request
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h0000_7F00,
  parameter int          CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t            r_state, w_state_nxt;
  logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt;
  logic [CNT_W-1:0]  r_preset, w_preset_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_irq_flag, w_irq_flag_nxt;
  logic              r_irq;

  logic w_sel;
  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_en;
  logic w_reload;
  logic w_unused_addr;

  assign w_sel         = (addr[31:4] == BASE[31:4]);
  assign w_wr_ctrl     = we && w_sel && (addr[3:2] == REG_CTRL);
  assign w_wr_preset   = we && w_sel && (addr[3:2] == REG_PRESET);
  assign w_en          = r_ctrl[CTRL_EN];
  assign w_unused_addr = &{1'b0, addr[1:0]};

  always_comb begin
    w_reload = 1'b0;
    case (r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB])
      MODE_RELOAD:  w_reload = 1'b1;
      MODE_ONESHOT: w_reload = 1'b0;
      default:      w_reload = 1'b0;
    endcase
  end

  // Bus writes clear the flag first so a flag set by the FSM in the same cycle is not lost.
  always_comb begin
    w_state_nxt    = r_state;
    w_ctrl_nxt     = r_ctrl;
    w_preset_nxt   = r_preset;
    w_count_nxt    = r_count;
    w_irq_flag_nxt = r_irq_flag;

    if (w_wr_ctrl || w_wr_preset) begin
      w_irq_flag_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_en) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count == '0) begin
          w_state_nxt    = ST_INT;
          w_irq_flag_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      ST_INT: begin
        if (w_reload) begin
          w_irq_flag_nxt = 1'b0;
          w_state_nxt    = ST_LOAD;
        end else begin
          w_ctrl_nxt[CTRL_EN] = 1'b0;
          w_state_nxt         = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A CTRL write overrides the one-shot EN clear in the INT cycle.
    if (w_wr_ctrl) begin
      w_ctrl_nxt = wdata[CTRL_W-1:0];
    end
    if (w_wr_preset) begin
      w_preset_nxt = wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_preset   <= w_preset_nxt;
      r_count    <= w_count_nxt;
      r_irq_flag <= w_irq_flag_nxt;
      r_irq      <= w_ctrl_nxt[CTRL_IM] & w_irq_flag_nxt;
    end
  end

  assign irq = r_irq;

  always_comb begin
    rdata = '0;
    if (w_sel) begin
      case (addr[3:2])
        REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
        REG_PRESET: rdata = 32'(r_preset);
        REG_COUNT:  rdata = 32'(r_count);
        REG_RSVD:   rdata = '0;
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - scoreboard bench for timer_dev against a run-age reference model
module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  timer_dev #(.BASE(BASE), .CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    logic [31:0] a;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  // Reference model: a run is described by its age in edges since leaving idle
  // (age 0 = about to load, ages 1..N+1 counting, age N+2 = interrupt cycle).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  logic        m_irq;
  bit          m_run;
  int          m_age;
  longint      m_n;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd0:    v = {28'd0, m_ctrl};
        2'd1:    v = m_preset;
        2'd2:    v = m_count;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        sel, wc, wp, en, rel;
    logic [3:0]  n_ctrl;
    logic [31:0] n_pre, n_count;
    logic        n_flag;
    bit          n_run;
    int          n_age;
    longint      n_n, left;
    if (r) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
      m_run = 1'b0; m_age = 0; m_n = 0; m_irq = 1'b0;
      return;
    end
    sel = (a[31:4] == BASE[31:4]);
    wc  = w && sel && (a[3:2] == 2'd0);
    wp  = w && sel && (a[3:2] == 2'd1);
    en  = m_ctrl[0];
    rel = (m_ctrl[2:1] == 2'b01);
    n_ctrl = m_ctrl; n_pre = m_preset; n_count = m_count; n_flag = m_flag;
    n_run = m_run; n_age = m_age; n_n = m_n;
    if (wc || wp) n_flag = 1'b0;
    if (!m_run) begin
      if (en) begin
        n_run = 1'b1;
        n_age = 0;
      end
    end else if (m_age == 0) begin
      n_n     = longint'(m_preset);
      n_count = m_preset;
      n_age   = 1;
    end else if (longint'(m_age) == m_n + 2) begin
      if (rel) begin
        n_flag = 1'b0;
        n_age  = 0;
      end else begin
        n_run     = 1'b0;
        n_ctrl[0] = 1'b0;
      end
    end else if (!en) begin
      n_run = 1'b0;
    end else begin
      n_age   = m_age + 1;
      left    = m_n - longint'(n_age - 1);
      n_count = (left > 0) ? left[31:0] : 32'd0;
      if (longint'(n_age) == m_n + 2) n_flag = 1'b1;
    end
    if (wc) n_ctrl = d[3:0];
    if (wp) n_pre = d;
    m_ctrl = n_ctrl; m_preset = n_pre; m_count = n_count; m_flag = n_flag;
    m_run = n_run; m_age = n_age; m_n = n_n;
    m_irq = m_ctrl[3] & m_flag;
  endtask

  // Monitor: one expected {rdata, irq} pair per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      total = total + 2;
      if (rdata !== e_mon.rd) begin
        bad = bad + 1;
        $display("FAIL rdata addr=%h got=%h expected=%h at %0t", e_mon.a, rdata, e_mon.rd, $time);
      end
      if (irq !== e_mon.irq) begin
        bad = bad + 1;
        $display("FAIL irq addr=%h got=%b expected=%b at %0t", e_mon.a, irq, e_mon.irq, $time);
      end
    end
  end

  task automatic check(input string name, input int got, input int expv);
    total = total + 1;
    if (got != expv) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    reset = r; we = w; addr = a; wdata = d;
    exp_q.push_back('{rd: model_read(a), irq: m_irq, a: a});
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    cycle(1'b0, 1'b1, BASE + off, d);
  endtask

  task automatic rd(input logic [31:0] off, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, BASE + off, 32'd0);
  endtask

  int lat, rises, highs, p0, p1;
  bit prev, seen;

  initial begin
    reset = 1'b1; we = 1'b0; addr = BASE; wdata = 32'd0;
    repeat (2) @(posedge clk);
    model_edge(1'b1, 1'b0, BASE, 32'd0);
    #1;

    // reset values, then reset in the middle of counting
    rd(32'h0, 1); rd(32'h4, 1); rd(32'h8, 1);
    wr(32'h4, 32'd10); wr(32'h0, 32'h9);
    rd(32'h8, 5);
    cycle(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    rd(32'h8, 1); rd(32'h0, 1); rd(32'h4, 1);

    // one-shot: PRESET=5, CTRL=0x9
    wr(32'h4, 32'd5); wr(32'h0, 32'h9);
    lat = -1;
    for (int i = 1; i <= 14; i++) begin
      cycle(1'b0, 1'b0, BASE, 32'd0);
      if (irq && lat < 0) lat = i;
    end
    check("oneshot_latency", lat, 8);
    check("oneshot_held", int'(irq), 1);
    wr(32'h0, 32'h8);
    check("oneshot_cleared", int'(irq), 0);
    rd(32'h0, 3);

    // auto-reload: PRESET=3, CTRL=0xB
    wr(32'h4, 32'd3); wr(32'h0, 32'hB);
    rises = 0; highs = 0; prev = 1'b0; p0 = -1; p1 = -1;
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0, 1'b0, BASE + 32'h8, 32'd0);
      if (irq) highs++;
      if (irq && !prev) begin
        rises++;
        if (p0 < 0) p0 = i; else if (p1 < 0) p1 = i;
      end
      prev = irq;
    end
    check("reload_first", p0, 6);
    check("reload_period", p1 - p0, 6);
    check("reload_width", highs, rises);
    wr(32'h0, 32'h0);
    rd(32'h8, 2);

    // mask: PRESET=2, CTRL=0x1, then expose with CTRL=0x8 which also clears the flag
    wr(32'h4, 32'd2); wr(32'h0, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, BASE, 32'd0);
      if (irq) seen = 1'b1;
    end
    check("mask_no_irq", int'(seen), 0);
    wr(32'h0, 32'h8);
    rd(32'h0, 3);

    // stop and restart
    wr(32'h4, 32'd9); wr(32'h0, 32'h9);
    rd(32'h8, 5);
    wr(32'h0, 32'h8);
    rd(32'h8, 4);
    wr(32'h0, 32'h9);
    rd(32'h8, 5);
    wr(32'h0, 32'h0);

    // decode
    wr(32'h8, 32'd55);
    rd(32'h8, 1); rd(32'hC, 1);
    cycle(1'b0, 1'b1, 32'h0000_8F00, 32'h5);
    cycle(1'b0, 1'b1, BASE + 32'h14, 32'd7);
    rd(32'h0, 1); rd(32'h4, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] off, a, d;
      r   = int'($urandom_range(0, 99));
      off = 32'($urandom_range(0, 3)) * 32'd4;
      a   = ($urandom_range(0, 9) == 0) ? ($urandom() & 32'hFFFF_FFFC) : BASE + off;
      d   = (off == 32'd4) ? 32'($urandom_range(0, 6)) : $urandom();
      if (r < 2) cycle(1'b1, 1'b0, a, 32'd0);
      else if (r < 22) cycle(1'b0, 1'b1, a, d);
      else cycle(1'b0, 1'b0, a, 32'd0);
    end

    we = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
